// File: rtl/spi_memory_pkg.sv
// spi_memory_pkg
//   Shared types and constants for the SPI-slave burst memory.
//   - spi_state_t : FSM state encoding
//   - SPI_READ / SPI_WRITE : value of the R/W bit that follows the address
//   - CPOL_BIT / CPHA_BIT and mode_cpol()/mode_cpha() : decode of SPI_MODE (0..3)
package spi_memory_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ADDR  = 3'd1,
    RW    = 3'd2,
    WRITE = 3'd3,
    READ  = 3'd4,
    DONE  = 3'd5
  } spi_state_t;

  localparam logic SPI_READ  = 1'b1;
  localparam logic SPI_WRITE = 1'b0;

  localparam int CPOL_BIT = 1;
  localparam int CPHA_BIT = 0;

  function automatic logic mode_cpol(input int mode);
    return mode[CPOL_BIT];
  endfunction

  function automatic logic mode_cpha(input int mode);
    return mode[CPHA_BIT];
  endfunction

endpackage

// File: rtl/spi_input_conditioner.sv
// spi_input_conditioner
//   Brings the asynchronous SPI pins into the clk domain and turns SCLK/CS
//   transitions into single-cycle strobes, decoded for the selected SPI mode.
// Ports:
//   clk, reset      : system clock, synchronous active-high reset
//   sclk_pin        : raw SPI clock
//   cs_pin          : raw chip select (active-low)
//   mosi_pin        : raw master data
//   sample_edge     : strobe, SCLK edge on which data is captured
//   shift_edge      : strobe, SCLK edge on which MISO advances
//   cs_fall/cs_rise : strobes on chip-select transitions
//   mosi_bit        : synchronized MOSI, aligned with sample_edge
import spi_memory_pkg::*;

module spi_input_conditioner #(
  parameter int SPI_MODE = 0
) (
  input  logic clk,
  input  logic reset,
  input  logic sclk_pin,
  input  logic cs_pin,
  input  logic mosi_pin,
  output logic sample_edge,
  output logic shift_edge,
  output logic cs_fall,
  output logic cs_rise,
  output logic mosi_bit
);

  localparam logic CPOL = mode_cpol(SPI_MODE);
  localparam logic CPHA = mode_cpha(SPI_MODE);

  logic [1:0] sclk_sync;
  logic [1:0] cs_sync;
  logic [1:0] mosi_sync;
  logic       sclk_d;
  logic       cs_d;

  // The synchronizer chain deliberately has no reset: it keeps tracking the
  // pins through a reset so that a CS held low across reset is not seen as a
  // fresh falling edge afterwards.
  always_ff @(posedge clk) begin
    sclk_sync <= {sclk_sync[0], sclk_pin};
    cs_sync   <= {cs_sync[0], cs_pin};
    mosi_sync <= {mosi_sync[0], mosi_pin};
    sclk_d    <= sclk_sync[1];
    cs_d      <= cs_sync[1];
  end

  logic sclk_chg;
  logic lead_edge;
  logic trail_edge;

  always_comb begin
    sclk_chg   = sclk_sync[1] ^ sclk_d;
    // leading edge leaves the idle level, trailing edge returns to it
    lead_edge  = sclk_chg && (sclk_d == CPOL);
    trail_edge = sclk_chg && (sclk_sync[1] == CPOL);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sample_edge <= 1'b0;
      shift_edge  <= 1'b0;
      cs_fall     <= 1'b0;
      cs_rise     <= 1'b0;
      mosi_bit    <= 1'b0;
    end else begin
      sample_edge <= CPHA ? trail_edge : lead_edge;
      shift_edge  <= CPHA ? lead_edge : trail_edge;
      cs_fall     <= cs_d & ~cs_sync[1];
      cs_rise     <= ~cs_d & cs_sync[1];
      mosi_bit    <= mosi_sync[1];
    end
  end

endmodule

// File: rtl/spi_memory_burst.sv
// spi_memory_burst
//   SPI-slave front end to a 2^ADDR_WIDTH x DATA_WIDTH register memory.
//   Frame: ADDR_WIDTH address bits, one R/W bit (1 = read), then data words,
//   all MSB first. Optional burst mode (macro SPI_BURST_EN) keeps transferring
//   words at an auto-incremented, wrapping address until CS rises; without it
//   a frame carries exactly one data word.
// Ports:
//   clk, reset : system clock, synchronous active-high reset
//   sclk_pin   : SPI clock (async)
//   cs_pin     : chip select, active-low (async)
//   mosi_pin   : master data in
//   miso_pin   : slave data out, 0 outside the read data phase
//   leds       : bits [3:0] of the last word written
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | CS high or frame dropped; waits for CS falling
// ADDR  | shifting in the address bits
// RW    | waiting for the R/W bit
// WRITE | shifting in a data word, written on its last bit
// READ  | shifting out the fetched word on MISO
// DONE  | single word done (non-burst); SCLK ignored until CS rises
import spi_memory_pkg::*;

module spi_memory_burst #(
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 8,
  parameter int SPI_MODE   = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sclk_pin,
  input  logic       cs_pin,
  input  logic       mosi_pin,
  output logic       miso_pin,
  output logic [3:0] leds
);

  localparam int MAX_W = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
  localparam int CNT_W = $clog2(MAX_W + 1);
  localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_WIDTH - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_WIDTH - 1);

  logic sample_edge;
  logic shift_edge;
  logic cs_fall;
  logic cs_rise;
  logic mosi_bit;

  spi_input_conditioner #(
    .SPI_MODE (SPI_MODE)
  ) u_cond (
    .clk         (clk),
    .reset       (reset),
    .sclk_pin    (sclk_pin),
    .cs_pin      (cs_pin),
    .mosi_pin    (mosi_pin),
    .sample_edge (sample_edge),
    .shift_edge  (shift_edge),
    .cs_fall     (cs_fall),
    .cs_rise     (cs_rise),
    .mosi_bit    (mosi_bit)
  );

  spi_state_t              state;
  logic [ADDR_WIDTH-1:0]   addr;
  logic [CNT_W-1:0]        bit_cnt;    // down-counter, last bit at 0
  logic [DATA_WIDTH-2:0]   shift_in;
  logic [DATA_WIDTH-1:0]   shift_out;
  logic                    fetch;
  logic [DATA_WIDTH-1:0]   mem [2**ADDR_WIDTH];

  logic [DATA_WIDTH-1:0]   word_in;
  logic                    wr_en;

  // CS rising on the same cycle as the last sample aborts the word.
  always_comb begin
    word_in = {shift_in, mosi_bit};
    wr_en   = (state == WRITE) && sample_edge && (bit_cnt == '0) && !cs_rise;
  end

  // Memory contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[addr] <= word_in;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      addr      <= '0;
      bit_cnt   <= '0;
      shift_in  <= '0;
      shift_out <= '0;
      fetch     <= 1'b0;
      miso_pin  <= 1'b0;
      leds      <= 4'b0000;
    end else begin
      fetch <= 1'b0;
      // one cycle after a fetch request, addr already holds the target
      if (fetch) shift_out <= mem[addr];

      if (cs_rise) begin
        state    <= IDLE;
        addr     <= '0;
        bit_cnt  <= '0;
        fetch    <= 1'b0;
        miso_pin <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            miso_pin <= 1'b0;
            if (cs_fall) begin
              state   <= ADDR;
              addr    <= '0;
              bit_cnt <= ADDR_LAST;
            end
          end

          ADDR: begin
            if (sample_edge) begin
              addr <= {addr[ADDR_WIDTH-2:0], mosi_bit};
              if (bit_cnt == '0) state <= RW;
              else bit_cnt <= bit_cnt - 1'b1;
            end
          end

          RW: begin
            if (sample_edge) begin
              bit_cnt <= DATA_LAST;
              if (mosi_bit == SPI_READ) begin
                state <= READ;
                fetch <= 1'b1;
              end else begin
                state <= WRITE;
              end
            end
          end

          WRITE: begin
            if (sample_edge) begin
              shift_in <= word_in[DATA_WIDTH-2:0];
              if (bit_cnt == '0) begin
                leds <= word_in[3:0];
`ifdef SPI_BURST_EN
                addr    <= addr + ADDR_WIDTH'(1);
                bit_cnt <= DATA_LAST;
`else
                state   <= DONE;
`endif
              end else begin
                bit_cnt <= bit_cnt - 1'b1;
              end
            end
          end

          READ: begin
            if (shift_edge) begin
              miso_pin  <= shift_out[DATA_WIDTH-1];
              shift_out <= {shift_out[DATA_WIDTH-2:0], 1'b0};
            end
            if (sample_edge) begin
              if (bit_cnt == '0) begin
`ifdef SPI_BURST_EN
                addr    <= addr + ADDR_WIDTH'(1);
                bit_cnt <= DATA_LAST;
                fetch   <= 1'b1;
`else
                state    <= DONE;
                miso_pin <= 1'b0;
`endif
              end else begin
                bit_cnt <= bit_cnt - 1'b1;
              end
            end
          end

          DONE: begin
            miso_pin <= 1'b0;
          end

          default: begin
            state    <= IDLE;
            miso_pin <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_memory_burst.sv
// tb_spi_memory_burst
//   Directed bench: one spi_memory_burst instance per SPI mode (0..3), each
//   with its own pins and reset, driven by a bit-banged SPI master task.
module tb_spi_memory_burst;

  localparam int H = 6;  // SCLK half period in clk cycles

  logic       clk;
  logic [3:0] rst;
  logic [3:0] sclk;
  logic [3:0] cs;
  logic [3:0] mosi;
  wire  [3:0] miso;
  logic [3:0] leds [4];

  logic [7:0] wr_buf [4];
  logic [7:0] rd_buf [4];
  logic       miso_bad;

  int n_checks = 0;
  int n_pass   = 0;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    spi_memory_burst #(
      .ADDR_WIDTH (7),
      .DATA_WIDTH (8),
      .SPI_MODE   (g)
    ) u_dut (
      .clk      (clk),
      .reset    (rst[g]),
      .sclk_pin (sclk[g]),
      .cs_pin   (cs[g]),
      .mosi_pin (mosi[g]),
      .miso_pin (miso[g]),
      .leds     (leds[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic bit_of(input int i, input logic [6:0] a, input logic rw);
    logic [7:0] w;
    if (i < 7) return a[6-i];
    if (i == 7) return rw;
    w = wr_buf[(i-8)/8];
    return w[7-((i-8)%8)];
  endfunction

  // One full CS-framed transfer on DUT m. ndata data bits follow the R/W bit;
  // read data lands in rd_buf. rst_bit >= 0 pulses that DUT's reset at the
  // start of the given bit.
  task automatic spi_xfer(input int m, input logic [6:0] a, input logic rw,
                          input int ndata, input int rst_bit);
    logic cpol;
    logic cpha;
    logic b;
    cpol = m[1];
    cpha = m[0];
    miso_bad = 1'b0;
    for (int w = 0; w < 4; w++) rd_buf[w] = 8'h00;
    cs[m] = 1'b0;
    wait_clk(H);
    for (int i = 0; i < 8 + ndata; i++) begin
      if (i == rst_bit) begin
        rst[m] = 1'b1;
        wait_clk(1);
        rst[m] = 1'b0;
        wait_clk(1);
        chk("midrst_miso", miso[m], 0);
        chk("midrst_leds", leds[m], 0);
      end
      b = bit_of(i, a, rw);
      if (!cpha) begin
        mosi[m] = b;
        wait_clk(H);
        sclk[m] = ~cpol;
      end else begin
        sclk[m] = ~cpol;
        mosi[m] = b;
        wait_clk(H);
        sclk[m] = cpol;
      end
      if (i >= 8 && rw) rd_buf[(i-8)/8][7-((i-8)%8)] = miso[m];
      else if (miso[m] !== 1'b0) miso_bad = 1'b1;
      wait_clk(H);
      if (!cpha) sclk[m] = cpol;
    end
    wait_clk(H);
    cs[m]   = 1'b1;
    mosi[m] = 1'b0;
    wait_clk(2*H);
    chk($sformatf("m%0d_idle_miso", m), miso[m], 0);
    chk($sformatf("m%0d_frame_miso0", m), miso_bad, 0);
  endtask

  initial begin
    rst  = 4'hF;
    cs   = 4'hF;
    mosi = 4'h0;
    sclk = 4'b1100;  // idle level = CPOL of each instance
    wait_clk(6);
    rst = 4'h0;
    wait_clk(2);

    for (int m = 0; m < 4; m++) begin
      chk($sformatf("m%0d_reset_miso", m), miso[m], 0);
      chk($sformatf("m%0d_reset_leds", m), leds[m], 0);
    end

    // mode 0 single write / read
    wr_buf[0] = 8'hB1;
    spi_xfer(0, 7'h61, 1'b0, 8, -1);
    chk("m0_wr_leds", leds[0], 4'h1);
    spi_xfer(0, 7'h61, 1'b1, 8, -1);
    chk("m0_rd_61", rd_buf[0], 8'hB1);

`ifdef SPI_BURST_EN
    wr_buf[0] = 8'h11;
    wr_buf[1] = 8'h22;
    wr_buf[2] = 8'h33;
    spi_xfer(0, 7'h7F, 1'b0, 24, -1);
    chk("burst_wr_leds", leds[0], 4'h3);
    spi_xfer(0, 7'h7F, 1'b1, 24, -1);
    chk("burst_rd_7f", rd_buf[0], 8'h11);
    chk("burst_rd_00", rd_buf[1], 8'h22);
    chk("burst_rd_01", rd_buf[2], 8'h33);
    spi_xfer(0, 7'h00, 1'b1, 8, -1);
    chk("wrap_single_rd_00", rd_buf[0], 8'h22);
`else
    wr_buf[0] = 8'h44;
    spi_xfer(0, 7'h11, 1'b0, 8, -1);
    chk("pre_wr_leds", leds[0], 4'h4);
    wr_buf[0] = 8'hAA;
    wr_buf[1] = 8'hBB;
    spi_xfer(0, 7'h10, 1'b0, 16, -1);
    chk("nb_wr_leds", leds[0], 4'hA);
    spi_xfer(0, 7'h10, 1'b1, 8, -1);
    chk("nb_rd_10", rd_buf[0], 8'hAA);
    spi_xfer(0, 7'h11, 1'b1, 8, -1);
    chk("nb_rd_11", rd_buf[0], 8'h44);
    spi_xfer(0, 7'h10, 1'b1, 16, -1);
    chk("nb_rd2_w0", rd_buf[0], 8'hAA);
    chk("nb_rd2_w1_done", rd_buf[1], 8'h00);
`endif

    // CS abort after 5 data bits
    wr_buf[0] = 8'h3C;
    spi_xfer(0, 7'h05, 1'b0, 8, -1);
    chk("abort_pre_leds", leds[0], 4'hC);
    wr_buf[0] = 8'hFF;
    spi_xfer(0, 7'h05, 1'b0, 5, -1);
    chk("abort_leds", leds[0], 4'hC);
    spi_xfer(0, 7'h05, 1'b1, 8, -1);
    chk("abort_rd_05", rd_buf[0], 8'h3C);

    // modes 1..3
    for (int m = 1; m < 4; m++) begin
      wr_buf[0] = 8'h5A;
      spi_xfer(m, 7'h02, 1'b0, 8, -1);
      chk($sformatf("m%0d_wr_leds", m), leds[m], 4'hA);
      spi_xfer(m, 7'h02, 1'b1, 8, -1);
      chk($sformatf("m%0d_rd_02", m), rd_buf[0], 8'h5A);
    end

    // reset during address bit 3; rest of that frame must be ignored
    wr_buf[0] = 8'hE7;
    spi_xfer(0, 7'h2A, 1'b0, 8, 3);
    chk("post_rst_leds", leds[0], 4'h0);
    wr_buf[0] = 8'h5C;
    spi_xfer(0, 7'h33, 1'b0, 8, -1);
    chk("post_rst_wr_leds", leds[0], 4'hC);
    spi_xfer(0, 7'h33, 1'b1, 8, -1);
    chk("post_rst_rd_33", rd_buf[0], 8'h5C);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/spi_memory_burst.md
# spi_memory_burst

Parametrised SPI-slave register memory: next generation of the team's `spiMemory`, with configurable address/data width, all four SPI modes and burst transfers with address auto-increment. Sits between the board-level SPI pins and a local on-chip RAM. Debug LEDs show the state of the last transaction. All SPI inputs are asynchronous and are oversampled on the system clock.

## Interface
Parameters:
- `ADDR_WIDTH`, 7: address bits per command; memory depth is 2^ADDR_WIDTH words.
- `DATA_WIDTH`, 8: bits per data word.
- `SPI_MODE`, 0: 0..3, where CPOL = bit 1 and CPHA = bit 0.

Ports (one clock; reset is synchronous, active-high):
- `clk` in 1: system clock, all logic.
- `reset` in 1: synchronous, active-high.
- `sclk_pin` in 1: SPI clock, asynchronous.
- `cs_pin` in 1: chip select, active-low, asynchronous.
- `mosi_pin` in 1: master data in, MSB first.
- `miso_pin` out 1: slave data out, MSB first.
- `leds` out 4: bits [3:0] of the last word written.

## Operation
- Inputs pass through the sub-module: 2-flop synchronizer, then edge detect, giving `sample_edge` and `shift_edge`.
- Edge mapping:
  - Leading edge = SCLK leaving its CPOL idle level.
  - CPHA=0: sample on the leading edge, shift on the trailing edge.
  - CPHA=1: sample on the trailing edge, shift on the leading edge.
- Frame format: ADDR_WIDTH address bits, then 1 R/W bit (1 = read, 0 = write), then data words of DATA_WIDTH bits.
- FSM states:
  - `IDLE`: CS high. Goes to `ADDR` on CS falling.
  - `ADDR`: shift MOSI into the address register. After ADDR_WIDTH samples, go to `RW`.
  - `RW`: on sample, go to `WRITE` or `READ`.
    - Read: fetch mem[addr] on the next clk and load the shift-out register.
  - `WRITE`: shift in DATA_WIDTH bits.
    - On the last sample: mem[addr] <= word, `leds` <= word[3:0], addr <= addr+1 (mod 2^ADDR_WIDTH), bit count = 0.
  - `READ`: drive MISO from the shift-out register MSB on each `shift_edge`.
    - On the sample of the last bit: addr <= addr+1, fetch the next word, load it before the next `shift_edge`.
  - `DONE` (burst disabled only): ignore SCLK and hold MISO=0 until CS rises.
- The first read bit is driven on the first `shift_edge` after the R/W sample.
- MISO is 0 in every state except `READ`.
- CS rising in any state: next clk go to `IDLE`, MISO=0.
  - A partial write word is discarded (no memory update, no LED change).
  - The address and bit counter are cleared.
- The memory array is not reset; its contents are undefined after reset.

## Timing
- Reset values: `miso_pin`=0, `leds`=4'b0000, FSM=`IDLE`, counters 0.
- Input-to-edge latency: 3 clk (2 sync + 1 detect).
- MISO change: 1 clk after `shift_edge` detection, i.e. 4 clk after the raw SCLK edge.
- Memory write: 1 clk after detection of the last data-bit sample.
- Read fetch: 1 clk after the R/W or last-bit sample. The loaded word is ready 2 clk after that sample.
- Constraint: each SCLK phase ≥ 4 clk, and CS setup/hold to SCLK ≥ 4 clk. Behaviour is undefined below this.
- Address wrap: 2^ADDR_WIDTH−1 increments to 0, for both read and write bursts.
- CS rising on the same clk as a last-bit sample: the abort wins, so no write and no increment occur.
- Reset asserted mid-frame: next clk to `IDLE`. The frame is dropped and CS must toggle before a new frame is accepted.

## Configuration
- `SPI_BURST_EN` defined:
  - After each word, stay in `WRITE`/`READ` at the incremented address.
  - This continues for any number of words until CS rises.
- `SPI_BURST_EN` undefined:
  - After one data word, go to `DONE`.
  - No address increment and no further reads or writes until CS rises.

## Structure
- Package `spi_memory_pkg`:
  - FSM state enum (`IDLE`, `ADDR`, `RW`, `WRITE`, `READ`, `DONE`).
  - R/W encoding constants (`SPI_READ`=1, `SPI_WRITE`=0).
  - Mode-decode helper constants for CPOL/CPHA.
- Sub-module `spi_input_conditioner`:
  - 2-flop synchronizers for sclk/cs/mosi.
  - Edge detector producing `sample_edge`, `shift_edge`, `cs_fall`, `cs_rise` per `SPI_MODE`.
- Top level: FSM, counters, shift registers and the memory array.

## Test plan
- Mode 0, write 8'hB1 to addr 7'h61, then a single read of 7'h61 → MISO bits 1,0,1,1,0,0,0,1; `leds`=4'b0001.
- Burst, `SPI_BURST_EN`: write 8'h11, 8'h22, 8'h33 starting at 7'h7F, then burst-read 3 words from 7'h7F → read data 11,22,33, with addresses wrapping 7F→00→01.
- Burst disabled: write 8'hAA, 8'hBB starting at 7'h10, then read 7'h10 and 7'h11 → 7'h10 reads 8'hAA; 7'h11 is unchanged from its prior known value.
- CS abort: raise CS after 5 data bits of a write of 8'hFF to 7'h05 (pre-written 8'h3C), then read 7'h05 → 8'h3C; `leds` unchanged.
- Modes 1, 2 and 3, each parameterised instance: write 8'h5A to 7'h02, then read back → 8'h5A; MISO=0 outside the data phase.
- Reset mid-address: assert `reset` for 1 clk during bit 3 → `miso_pin`=0; the next full frame (after a CS toggle) completes correctly.
